// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, constants and fetch entry type for the front end
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// rtl/if_prefetch_if.sv - instruction memory and decode-side handshake bundle
interface if_prefetch_if;
    import cpu_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    current_pc;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output instruction,
        output current_pc,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  instruction,
        input  current_pc,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of {pc, instr} entries; flush beats push and pop
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 entry,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH):0]       count,
    output fetch_entry_t                 head,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   COUNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == FULL_COUNT);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= entry;
    end

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - fetch stage: PC, credit-limited imem requests, redirect flush, prefetch FIFO
module if_prefetch
    import cpu_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] branch_addr,
    input  logic            branch_ctrl,
    input  logic [PC_W-1:0] jump_addr,
    input  logic            jump_ctrl,
    if_prefetch_if.master   bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] req_pc;
    logic [PC_W-1:0] redirect_pc;
    logic            inflight;
    logic            redirect;
    logic            issue;
    logic            pop;
    logic [CW-1:0]   count;
    logic [CW:0]     credits_used;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    logic            empty;
    logic            full;

    // Buffered entries plus the outstanding request must fit, so a response
    // always has a free slot when it lands.
    always_comb begin
        redirect     = jump_ctrl || branch_ctrl;
        redirect_pc  = word_align(jump_ctrl ? jump_addr : branch_addr);
        credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};
        issue        = !rst && !redirect && (credits_used < CREDIT_LIMIT);
        push_entry   = '{pc: req_pc, instr: bus.imem_rdata};
    end

    always_comb begin
        bus.imem_req    = issue;
        bus.imem_addr   = word_align(fetch_pc);
        bus.out_valid   = !rst && !empty;
        bus.instruction = bus.out_valid ? head.instr : NOP_INSTR;
        bus.current_pc  = bus.out_valid ? head.pc : '0;
        pop             = bus.out_valid && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= word_align(RESET_PC);
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
                req_pc   <= fetch_pc;
            end
        end
    end

    // A response landing during a redirect cycle is dropped by the flush.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .entry (push_entry),
        .pop   (pop),
        .flush (redirect),
        .count (count),
        .head  (head),
        .empty (empty),
        .full  (full)
    );

    push_when_full_a: assert property (@(posedge clk) disable iff (rst)
        !(inflight && full && !redirect));

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - directed table and sequence checks for the prefetching fetch stage
module tb_if_prefetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] branch_addr = '0;
    logic        branch_ctrl = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        jump_ctrl = 1'b0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    if_prefetch_if bus ();

    if_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .branch_addr (branch_addr),
        .branch_ctrl (branch_ctrl),
        .jump_addr   (jump_addr),
        .jump_ctrl   (jump_ctrl),
        .bus         (bus.master)
    );

    // Instruction memory with mem[a] = a and one cycle of read latency.
    always @(posedge clk) bus.imem_rdata <= bus.imem_addr;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic rdy, input logic rq, input logic [31:0] a,
                       input logic v, input logic [31:0] p);
        vec_t t;
        t.rst = r; t.ready = rdy; t.req = rq; t.addr = a; t.valid = v; t.pc = p;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        bus.out_ready = 1'b1;

        // Reset, free run, mid-stream reset, then a 10-cycle stall and drain.
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 32'd0,  0, 0);
        add(0, 1, 1, 32'd4,  0, 0);
        add(0, 1, 1, 32'd8,  1, 32'd0);
        add(0, 1, 1, 32'd12, 1, 32'd4);
        add(0, 1, 1, 32'd16, 1, 32'd8);
        add(0, 1, 1, 32'd20, 1, 32'd12);
        add(1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 32'd0,  0, 0);
        add(0, 0, 1, 32'd4,  0, 0);
        add(0, 0, 1, 32'd8,  1, 32'd0);
        add(0, 0, 1, 32'd12, 1, 32'd0);
        for (int i = 4; i < 10; i++) add(0, 0, 0, 0, 1, 32'd0);
        add(0, 1, 0, 0, 1, 32'd0);
        add(0, 1, 1, 32'd16, 1, 32'd4);
        add(0, 1, 1, 32'd20, 1, 32'd8);
        add(0, 1, 1, 32'd24, 1, 32'd12);
        add(0, 1, 1, 32'd28, 1, 32'd16);
        add(0, 1, 1, 32'd32, 1, 32'd20);

        tick();
        for (int i = 0; i < vq.size(); i++) begin
            rst           = vq[i].rst;
            bus.out_ready = vq[i].ready;
            settle();
            chk($sformatf("vec%0d_req", i), {31'd0, bus.imem_req}, {31'd0, vq[i].req});
            if (vq[i].req) chk($sformatf("vec%0d_addr", i), bus.imem_addr, vq[i].addr);
            chk($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid}, {31'd0, vq[i].valid});
            chk($sformatf("vec%0d_pc", i), bus.current_pc, vq[i].valid ? vq[i].pc : 32'd0);
            chk($sformatf("vec%0d_instr", i), bus.instruction, vq[i].valid ? vq[i].pc : 32'd0);
            tick();
        end

        // Branch with three entries queued and one response in flight.
        rst = 1'b1; bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        branch_ctrl = 1'b1; branch_addr = 32'h0000_0102;
        settle();
        chk("br_no_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        branch_ctrl = 1'b0;
        settle();
        chk("br_flushed", {31'd0, bus.out_valid}, 32'd0);
        chk("br_req", {31'd0, bus.imem_req}, 32'd1);
        chk("br_addr", bus.imem_addr, 32'h0000_0100);
        tick();
        settle();
        chk("br_squashed", {31'd0, bus.out_valid}, 32'd0);
        chk("br_addr2", bus.imem_addr, 32'h0000_0104);
        tick();
        bus.out_ready = 1'b1;
        settle();
        chk("br_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("br_pc", bus.current_pc, 32'h0000_0100);
        chk("br_instr", bus.instruction, 32'h0000_0100);
        tick();
        settle();
        chk("br_pc2", bus.current_pc, 32'h0000_0104);
        tick();

        // Jump and branch together: jump wins.
        jump_ctrl = 1'b1; jump_addr = 32'h0000_0400;
        branch_ctrl = 1'b1; branch_addr = 32'h0000_0800;
        settle();
        chk("jb_no_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        jump_ctrl = 1'b0; branch_ctrl = 1'b0;
        settle();
        chk("jb_req", {31'd0, bus.imem_req}, 32'd1);
        chk("jb_addr", bus.imem_addr, 32'h0000_0400);
        tick();

        // Redirect right after the 0x400 issue, then PC wraps past the top.
        jump_ctrl = 1'b1; jump_addr = 32'hFFFF_FFF8;
        tick();
        jump_ctrl = 1'b0;
        settle();
        chk("wr_addr0", bus.imem_addr, 32'hFFFF_FFF8);
        chk("wr_empty", {31'd0, bus.out_valid}, 32'd0);
        tick();
        settle();
        chk("wr_addr1", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        settle();
        chk("wr_addr2", bus.imem_addr, 32'h0000_0000);
        begin
            logic [31:0] exp_pcs [4];
            exp_pcs[0] = 32'hFFFF_FFF8; exp_pcs[1] = 32'hFFFF_FFFC;
            exp_pcs[2] = 32'h0000_0000; exp_pcs[3] = 32'h0000_0004;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin tick(); settle(); end
                chk($sformatf("wr_valid%0d", k), {31'd0, bus.out_valid}, 32'd1);
                chk($sformatf("wr_pc%0d", k), bus.current_pc, exp_pcs[k]);
                chk($sformatf("wr_instr%0d", k), bus.instruction, exp_pcs[k]);
            end
        end
        tick();

        // Fill the FIFO, then a single reset cycle.
        bus.out_ready = 1'b0;
        repeat (6) tick();
        settle();
        chk("full_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("full_no_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        rst = 1'b1;
        settle();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("post_rst_instr", bus.instruction, 32'd0);
        chk("post_rst_pc", bus.current_pc, 32'd0);
        chk("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
        chk("post_rst_addr", bus.imem_addr, 32'h0000_0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
